// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcode helpers and the IR capture pattern.
// Opcode helpers take the IR width so every instance derives its own constants.
package jtag_pkg;

  // Standard 1149.1 state encoding, exposed on tap_state.
  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  localparam int MAX_IR_WIDTH = 8;

  // All-ones mask of the given IR width.
  function automatic logic [MAX_IR_WIDTH-1:0] ir_mask(input int w);
    return MAX_IR_WIDTH'((1 << w) - 1);
  endfunction

  function automatic logic [MAX_IR_WIDTH-1:0] op_extest(input int w);
    return MAX_IR_WIDTH'(0) & ir_mask(w);
  endfunction

  function automatic logic [MAX_IR_WIDTH-1:0] op_sample(input int w);
    return MAX_IR_WIDTH'(1) & ir_mask(w);
  endfunction

  function automatic logic [MAX_IR_WIDTH-1:0] op_idcode(input int w);
    return MAX_IR_WIDTH'(2) & ir_mask(w);
  endfunction

  function automatic logic [MAX_IR_WIDTH-1:0] op_intest(input int w);
    return MAX_IR_WIDTH'(3) & ir_mask(w);
  endfunction

  // USER_k is op_user_base + k.
  function automatic logic [MAX_IR_WIDTH-1:0] op_user_base(input int w);
    return MAX_IR_WIDTH'(4) & ir_mask(w);
  endfunction

  function automatic logic [MAX_IR_WIDTH-1:0] op_bypass(input int w);
    return ir_mask(w);
  endfunction

  // Value loaded into the IR shift register in CAP_IR: {0..0,2'b01}.
  function automatic logic [MAX_IR_WIDTH-1:0] ir_capture(input int w);
    return MAX_IR_WIDTH'(1) & ir_mask(w);
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Chip-level JTAG serial pins. The pin driver (board/tester) is the master,
// the TAP controller is the slave.
interface jtag_tap_ctrl_if;
  logic TMS;
  logic TDI;
  logic TDO;
  logic tdo_en;

  modport master (output TMS, output TDI, input TDO, input tdo_en);
  modport slave  (input TMS, input TDI, output TDO, output tdo_en);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller FSM with registered per-state decode flags.
// tlr_next is combinational so the IR can be forced on the edge entering TLR.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_e state,
  output logic       tlr_next,
  output logic       in_tlr,
  output logic       in_cap_dr,
  output logic       in_sh_dr,
  output logic       in_upd_dr,
  output logic       in_cap_ir,
  output logic       in_sh_ir,
  output logic       in_upd_ir
);

  tap_state_e nxt;

  function automatic tap_state_e next_state(input tap_state_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      UPD_IR:  return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  // Next state from the 1149.1 transition table.
  always_comb nxt = next_state(state, tms);

  assign tlr_next = (nxt == TLR);

  // State register; decode flags are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge tck) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= TLR;
      in_tlr    <= 1'b1;
      in_cap_dr <= 1'b0;
      in_sh_dr  <= 1'b0;
      in_upd_dr <= 1'b0;
      in_cap_ir <= 1'b0;
      in_sh_ir  <= 1'b0;
      in_upd_ir <= 1'b0;
    end else begin
      state     <= nxt;
      in_tlr    <= (nxt == TLR);
      in_cap_dr <= (nxt == CAP_DR);
      in_sh_dr  <= (nxt == SH_DR);
      in_upd_dr <= (nxt == UPD_DR);
      in_cap_ir <= (nxt == CAP_IR);
      in_sh_ir  <= (nxt == SH_IR);
      in_upd_ir <= (nxt == UPD_IR);
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Parametrised TAP controller: FSM, instruction register, decode, bypass,
// optional IDCODE register and TDO mux. Boundary and user scan chains are
// external and driven through the decoded strobes/selects.
// Build option: define IDCODE_EN to include the 32-bit IDCODE register and
// make IDCODE the reset instruction (otherwise BYPASS).
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          N_USER     = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                reset,
  jtag_tap_ctrl_if.slave      jtag,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                bsr_sel,
  output logic                bsr_mode,
  input  logic                bsr_tdo,
  output logic [N_USER-1:0]   user_sel,
  input  logic [N_USER-1:0]   user_tdo,
  output logic                tap_reset
);

  // Elaboration-time parameter legality.
  if (IR_WIDTH < 3 || IR_WIDTH > MAX_IR_WIDTH) begin : g_chk_ir_width
    $error("jtag_tap_ctrl: IR_WIDTH must be 3..8");
  end
  if (N_USER < 1 || N_USER > 8 || (1 << IR_WIDTH) < N_USER + 5) begin : g_chk_n_user
    $error("jtag_tap_ctrl: N_USER must be 1..8 and fit the opcode space");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_chk_idcode
    $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
  end

  localparam logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(op_extest(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(op_sample(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] OP_INTEST  = IR_WIDTH'(op_intest(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(ir_capture(IR_WIDTH));
`ifdef IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(op_idcode(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = IR_WIDTH'(op_bypass(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_BYPASS;
`endif

  tap_state_e          state;
  logic                tlr_next;
  logic                in_tlr, in_cap_dr, in_sh_dr, in_upd_dr;
  logic                in_cap_ir, in_sh_ir, in_upd_ir;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir;
  logic                bypass_q;
  logic                dr_int_tdo;
  logic                ext_sel;
  logic                tdo_mux;

  jtag_tap_fsm u_fsm (
    .tck       (TCK),
    .reset     (reset),
    .tms       (jtag.TMS),
    .state     (state),
    .tlr_next  (tlr_next),
    .in_tlr    (in_tlr),
    .in_cap_dr (in_cap_dr),
    .in_sh_dr  (in_sh_dr),
    .in_upd_dr (in_upd_dr),
    .in_cap_ir (in_cap_ir),
    .in_sh_ir  (in_sh_ir),
    .in_upd_ir (in_upd_ir)
  );

  // IR shift register: capture pattern, then shift right with TDI into the MSB.
  always_ff @(posedge TCK) begin
    if (reset)          ir_sr <= '0;
    else if (in_cap_ir) ir_sr <= IR_CAPTURE;
    else if (in_sh_ir)  ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};
  end

  // Active instruction: forced to the reset opcode on entering TLR, otherwise
  // updated only from the shift register in UPD_IR.
  always_ff @(posedge TCK) begin
    if (reset || tlr_next) ir <= IR_RESET;
    else if (in_upd_ir)    ir <= ir_sr;
  end

  // Single-bit bypass register.
  always_ff @(posedge TCK) begin
    if (reset)          bypass_q <= 1'b0;
    else if (in_cap_dr) bypass_q <= 1'b0;
    else if (in_sh_dr)  bypass_q <= jtag.TDI;
  end

`ifdef IDCODE_EN
  logic [31:0] idcode_sr;
  logic        sel_idcode;

  assign sel_idcode = (ir == OP_IDCODE);

  // IDCODE register: load the device ID on capture, shift right with TDI into bit 31.
  always_ff @(posedge TCK) begin
    if (reset)                        idcode_sr <= IDCODE_VAL;
    else if (in_cap_dr && sel_idcode) idcode_sr <= IDCODE_VAL;
    else if (in_sh_dr && sel_idcode)  idcode_sr <= {jtag.TDI, idcode_sr[31:1]};
  end

  assign dr_int_tdo = sel_idcode ? idcode_sr[0] : bypass_q;
`else
  assign dr_int_tdo = bypass_q;
`endif

  // Instruction decode from the active instruction; anything unlisted is bypass.
  assign bsr_sel  = (ir == OP_EXTEST) || (ir == OP_SAMPLE) || (ir == OP_INTEST);
  assign bsr_mode = (ir == OP_EXTEST) || (ir == OP_INTEST);

  for (genvar k = 0; k < N_USER; k++) begin : g_user_sel
    assign user_sel[k] = (ir == IR_WIDTH'(int'(op_user_base(IR_WIDTH)) + k));
  end

  assign ext_sel    = bsr_sel | (|user_sel);
  assign capture_dr = in_cap_dr & ext_sel;
  assign shift_dr   = in_sh_dr  & ext_sel;
  assign update_dr  = in_upd_dr & ext_sel;

  // TDO mux: IR LSB in SH_IR, the selected data register in SH_DR, else 0.
  always_comb begin
    // NOTE: default assigned first so every path drives tdo_mux and no latch is inferred.
    tdo_mux = 1'b0;
    if (in_sh_ir) begin
      tdo_mux = ir_sr[0];
    end else if (in_sh_dr) begin
      if (bsr_sel)          tdo_mux = bsr_tdo;
      else if (|user_sel)   tdo_mux = |(user_sel & user_tdo);
      else                  tdo_mux = dr_int_tdo;
    end
  end

  assign jtag.TDO    = tdo_mux;
  assign jtag.tdo_en = in_sh_ir | in_sh_dr;
  assign tap_state   = state;
  assign ir_o        = ir;
  assign tap_reset   = in_tlr;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed scenarios plus a random TMS/TDI
// walk, all compared against a shift-queue reference model of the TAP.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  localparam int          IRW = 4;
  localparam int          NU  = 2;
  localparam logic [31:0] IDV = 32'h1000_0001;
  localparam int          OP_BYP = (1 << IRW) - 1;
`ifdef IDCODE_EN
  localparam int          IR_RST = 2;
`else
  localparam int          IR_RST = OP_BYP;
`endif

  logic          tck;
  logic          reset;
  logic [3:0]    tap_state;
  logic [IRW-1:0] ir_o;
  logic          capture_dr, shift_dr, update_dr;
  logic          bsr_sel, bsr_mode, bsr_tdo, tap_reset;
  logic [NU-1:0] user_sel, user_tdo;

  jtag_tap_ctrl_if jif ();

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .N_USER(NU), .IDCODE_VAL(IDV)) dut (
    .TCK        (tck),
    .reset      (reset),
    .jtag       (jif),
    .tap_state  (tap_state),
    .ir_o       (ir_o),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .bsr_sel    (bsr_sel),
    .bsr_mode   (bsr_mode),
    .bsr_tdo    (bsr_tdo),
    .user_sel   (user_sel),
    .user_tdo   (user_tdo),
    .tap_reset  (tap_reset)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  tap_state_e t_next0 [16];
  tap_state_e t_next1 [16];
  tap_state_e m_st;
  int         m_ir;
  bit         m_irq[$];   // IR shift register, element 0 is the TDO end
  bit         m_drq[$];   // internal data register (bypass or IDCODE), element 0 is the TDO end
  bit         rand_ext = 1'b1;

  task automatic set_tr(input tap_state_e s, input tap_state_e n0, input tap_state_e n1);
    t_next0[s] = n0;
    t_next1[s] = n1;
  endtask

  task automatic init_table();
    set_tr(TLR,    RTI,    TLR);
    set_tr(RTI,    RTI,    SEL_DR);
    set_tr(SEL_DR, CAP_DR, SEL_IR);
    set_tr(CAP_DR, SH_DR,  EX1_DR);
    set_tr(SH_DR,  SH_DR,  EX1_DR);
    set_tr(EX1_DR, PA_DR,  UPD_DR);
    set_tr(PA_DR,  PA_DR,  EX2_DR);
    set_tr(EX2_DR, SH_DR,  UPD_DR);
    set_tr(UPD_DR, RTI,    SEL_DR);
    set_tr(SEL_IR, CAP_IR, TLR);
    set_tr(CAP_IR, SH_IR,  EX1_IR);
    set_tr(SH_IR,  SH_IR,  EX1_IR);
    set_tr(EX1_IR, PA_IR,  UPD_IR);
    set_tr(PA_IR,  PA_IR,  EX2_IR);
    set_tr(EX2_IR, SH_IR,  UPD_IR);
    set_tr(UPD_IR, RTI,    SEL_DR);
  endtask

  function automatic bit m_bsr(input int ir);
    return (ir == 0) || (ir == 1) || (ir == 3);
  endfunction

  function automatic bit m_mode(input int ir);
    return (ir == 0) || (ir == 3);
  endfunction

  function automatic int m_user(input int ir);
    return (ir >= 4 && ir < 4 + NU) ? ir - 4 : -1;
  endfunction

  function automatic bit m_idsel(input int ir);
`ifdef IDCODE_EN
    return ir == 2;
`else
    return (ir == -1);
`endif
  endfunction

  task automatic model_reset();
    m_st = TLR;
    m_ir = IR_RST;
    m_irq = {};
    for (int i = 0; i < IRW; i++) m_irq.push_back(1'b0);
    m_drq = {1'b0};
  endtask

  task automatic model_edge(input bit tms_v, input bit tdi_v, input bit rst_v);
    bit ext;
    if (rst_v) begin
      model_reset();
      return;
    end
    ext = m_bsr(m_ir) || (m_user(m_ir) >= 0);
    case (m_st)
      CAP_IR: begin
        m_irq = {1'b1};
        for (int i = 1; i < IRW; i++) m_irq.push_back(1'b0);
      end
      SH_IR: begin
        void'(m_irq.pop_front());
        m_irq.push_back(tdi_v);
      end
      UPD_IR: begin
        m_ir = 0;
        for (int i = 0; i < IRW; i++) m_ir += int'(m_irq[i]) << i;
      end
      CAP_DR: if (!ext) begin
        m_drq = {};
        if (m_idsel(m_ir)) for (int i = 0; i < 32; i++) m_drq.push_back(IDV[i]);
        else m_drq.push_back(1'b0);
      end
      SH_DR: if (!ext) begin
        void'(m_drq.pop_front());
        m_drq.push_back(tdi_v);
      end
      default: ;
    endcase
    m_st = tms_v ? t_next1[m_st] : t_next0[m_st];
    if (m_st == TLR) m_ir = IR_RST;
  endtask

  task automatic check_outputs();
    int ui;
    bit bs, ext, e_tdo;
    logic [NU-1:0] e_usel;
    ui     = m_user(m_ir);
    bs     = m_bsr(m_ir);
    ext    = bs || (ui >= 0);
    e_usel = (ui >= 0) ? NU'(1 << ui) : '0;
    e_tdo  = 1'b0;
    if (m_st == SH_IR) e_tdo = m_irq[0];
    else if (m_st == SH_DR) e_tdo = bs ? bsr_tdo : ((ui >= 0) ? user_tdo[ui] : m_drq[0]);
    check("tap_state",  32'(tap_state),  32'(m_st));
    check("tap_reset",  32'(tap_reset),  32'(m_st == TLR));
    check("tdo_en",     32'(jif.tdo_en), 32'(m_st == SH_IR || m_st == SH_DR));
    check("ir_o",       32'(ir_o),       32'(m_ir));
    check("bsr_sel",    32'(bsr_sel),    32'(bs));
    check("bsr_mode",   32'(bsr_mode),   32'(m_mode(m_ir)));
    check("user_sel",   32'(user_sel),   32'(e_usel));
    check("capture_dr", 32'(capture_dr), 32'(ext && m_st == CAP_DR));
    check("shift_dr",   32'(shift_dr),   32'(ext && m_st == SH_DR));
    check("update_dr",  32'(update_dr),  32'(ext && m_st == UPD_DR));
    check("tdo",        32'(jif.TDO),    32'(e_tdo));
  endtask

  // One TCK cycle: drive at the falling edge, check, clock, advance the model.
  task automatic step(input bit tms_v, input bit tdi_v, input bit rst_v, output bit tdo_seen);
    jif.TMS = tms_v;
    jif.TDI = tdi_v;
    reset   = rst_v;
    if (rand_ext) begin
      bsr_tdo  = 1'($urandom);
      user_tdo = NU'($urandom);
    end
    #1;
    check_outputs();
    tdo_seen = jif.TDO;
    @(posedge tck);
    model_edge(tms_v, tdi_v, rst_v);
    @(negedge tck);
  endtask

  task automatic tms_step(input bit v);
    bit d;
    step(v, 1'($urandom), 1'b0, d);
  endtask

  // From RTI: load an instruction, return the captured bits seen on TDO. Ends in RTI.
  task automatic load_ir(input int val, output logic [7:0] seen);
    bit t;
    seen = '0;
    tms_step(1); tms_step(1); tms_step(0); tms_step(0);
    for (int i = 0; i < IRW; i++) begin
      step(i == IRW - 1, 1'((val >> i) & 1), 1'b0, t);
      seen[i] = t;
    end
    tms_step(1); tms_step(0);
  endtask

  // From RTI: capture and shift n DR bits, returning TDO bits. Ends in RTI.
  task automatic shift_dr_bits(input logic [31:0] din, input int n, output logic [31:0] dout);
    bit t;
    dout = '0;
    tms_step(1); tms_step(0); tms_step(0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], 1'b0, t);
      dout[i] = t;
    end
    tms_step(1); tms_step(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  irbits;
    logic [31:0] dout;
    bit          d;

    init_table();
    jif.TMS = 1'b0; jif.TDI = 1'b0; reset = 1'b1;
    bsr_tdo = 1'b0; user_tdo = '0;
    @(posedge tck);
    @(negedge tck);
    model_reset();

    // Reset state, then one TMS=0 clock into RTI.
    step(0, 0, 1, d);
    step(0, 0, 0, d);
    check("rti_state", 32'(tap_state), 32'(4'hC));
    check("rti_ir",    32'(ir_o),      32'(IR_RST));
    check("rti_tap_reset", 32'(tap_reset), 32'(0));

    // SAMPLE: captured 0001 appears LSB first on TDO.
    load_ir(1, irbits);
    check("sample_ir_capture_tdo", 32'(irbits[IRW-1:0]), 32'h1);
    check("sample_ir",       32'(ir_o),     32'h1);
    check("sample_bsr_sel",  32'(bsr_sel),  32'h1);
    check("sample_bsr_mode", 32'(bsr_mode), 32'h0);

    // Opcode 2: IDCODE when enabled, bypass otherwise.
    load_ir(2, irbits);
`ifdef IDCODE_EN
    shift_dr_bits(32'h0, 32, dout);
    check("idcode_serial", dout, 32'h1000_0001);
`else
    shift_dr_bits(32'h0000_00A5, 8, dout);
    check("op2_bypass_serial", dout, 32'h0000_004A);
`endif

    // USER_1 with fixed chain outputs, including a pause in the middle.
    load_ir(5, irbits);
    rand_ext = 1'b0;
    bsr_tdo = 1'b0;
    user_tdo = 2'b10;
    check("user1_sel", 32'(user_sel), 32'h2);
    tms_step(1); tms_step(0); tms_step(0);
    check("user1_shift_dr", 32'(shift_dr), 32'h1);
    check("user1_tdo",      32'(jif.TDO),  32'h1);
    tms_step(0); tms_step(1); tms_step(0);
    check("user1_pause_shift_dr", 32'(shift_dr), 32'h0);
    tms_step(0); tms_step(1); tms_step(0); tms_step(1); tms_step(1); tms_step(0);
    rand_ext = 1'b1;

    // Undefined opcode acts as bypass: TDO repeats TDI one clock later.
    load_ir(4'hB, irbits);
    check("undef_bsr_sel",  32'(bsr_sel),  32'h0);
    check("undef_user_sel", 32'(user_sel), 32'h0);
    shift_dr_bits(32'h5, 4, dout);
    check("undef_bypass_serial", dout, 32'hA);

    // Zero-shift IR: CAP_IR straight to EX1_IR, then update with the captured pattern.
    tms_step(1); tms_step(1); tms_step(0); tms_step(1); tms_step(1); tms_step(0);
    check("zero_shift_ir", 32'(ir_o), 32'h1);

    // TMS held high mid SH_IR: five clocks reach TLR, partial IR discarded.
    tms_step(1); tms_step(1); tms_step(0); tms_step(0);
    step(0, 1, 0, d); step(0, 0, 0, d);
    for (int i = 0; i < 5; i++) tms_step(1);
    check("tms_tlr_state", 32'(tap_state), 32'(4'hF));
    check("tms_tlr_ir",    32'(ir_o),      32'(IR_RST));
    tms_step(0);

    // Reset mid SH_DR.
    load_ir(1, irbits);
    tms_step(1); tms_step(0); tms_step(0);
    step(0, 1, 0, d);
    step(0, 0, 1, d);
    check("rst_mid_shift_state", 32'(tap_state), 32'(4'hF));
    check("rst_mid_shift_ir",    32'(ir_o),      32'(IR_RST));
    check("rst_mid_shift_tdo_en", 32'(jif.tdo_en), 32'h0);

    // Random walk.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 35, 1'($urandom), $urandom_range(0, 299) == 0, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
Parametrised IEEE 1149.1-style TAP controller, the successor to the fixed 3-bit-IR TAP used in the scan-wrapped SDRAM controller top.
- Integrates in one block: 16-state TAP FSM, instruction register of configurable width, instruction decode, bypass register, optional IDCODE register, and TDO mux.
- The boundary scan register and N_USER user scan chains stay external and are driven through decoded strobes and selects.
- Sits between the chip-level JTAG pins and the boundary/user scan registers.

Parameters:
IR_WIDTH, 4, instruction register width; legal range 3..8; must satisfy 2^IR_WIDTH >= N_USER+5
N_USER, 2, number of external user data registers; legal range 1..8
IDCODE_VAL, 32'h1000_0001, value loaded into IDCODE on Capture-DR; bit 0 must be 1; used only with IDCODE_EN

Ports:
TCK  in  1  test clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
TMS  in  1  test mode select
TDI  in  1  test data in
TDO  out  1  serial data out
tdo_en  out  1  TDO output-enable; 1 only in SHIFT_IR and SHIFT_DR
tap_state  out  4  current FSM state encoding
ir_o  out  IR_WIDTH  active (updated) instruction
capture_dr  out  1  high while state==CAPTURE_DR and an external register is selected
shift_dr  out  1  high while state==SHIFT_DR and an external register is selected
update_dr  out  1  high while state==UPDATE_DR and an external register is selected
bsr_sel  out  1  boundary scan register selected (EXTEST, SAMPLE, INTEST)
bsr_mode  out  1  BSR drives core/pins (EXTEST, INTEST)
bsr_tdo  in  1  serial out of external BSR
user_sel  out  N_USER  one-hot select of user chain k
user_tdo  in  N_USER  serial outs of user chains
tap_reset  out  1  high while in TEST_LOGIC_RESET

Behaviour:
Clocking and reset
- Single clock TCK. reset is synchronous and active-high.
- On reset: state=TEST_LOGIC_RESET (TLR); ir=IDCODE opcode (BYPASS if IDCODE_EN undefined); IR shift reg=0; bypass bit=0.
- Output values in reset: tdo_en=0, TDO=0, tap_state=TLR, strobes=0, bsr_sel=0, bsr_mode=0, user_sel=0, tap_reset=1.

FSM
- Standard 16 states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- Transitions follow 1149.1 exactly on TMS at each rising edge.
- TMS=1 for 5 consecutive clocks reaches TLR from any state.
- Entering TLR (by TMS or reset) forces ir to its reset value on the same edge.

Opcodes
- EXTEST=all-0; SAMPLE=1; IDCODE=2; INTEST=3; USER_k=4+k; BYPASS=all-1.
- Any undefined opcode decodes as BYPASS.

Instruction register
- CAP_IR loads {0..0,2'b01}.
- SH_IR shifts right: TDI enters the MSB, the LSB goes to TDO.
- UPD_IR copies the shift register to ir.
- ir changes only in UPD_IR or TLR.

Data registers
- Bypass: CAP_DR loads 0; SH_DR loads TDI; TDO=bypass bit.
- IDCODE: 32-bit; CAP_DR loads IDCODE_VAL; SH_DR shifts right with TDI into bit 31.
- Data register selection decodes from ir (the active instruction), never from the IR shift register.

Strobes and selects
- capture_dr/shift_dr/update_dr are decoded combinationally from the registered state and gated by (bsr_sel | |user_sel).
- Each strobe is high for exactly the cycles the FSM occupies that state; no strobe during pause/exit states.

TDO and tdo_en
- TDO is combinational.
- SH_IR: TDO = IR shift LSB.
- SH_DR: TDO is the selected register out (bsr_tdo, user_tdo[k], IDCODE LSB, or bypass).
- Otherwise TDO=0.
- tdo_en = (state==SH_IR | state==SH_DR).

Boundary cases
- Capture immediately followed by Exit1 (zero shift cycles) leaves registers holding the captured value.
- Reset asserted mid-shift aborts the shift; the ir update does not occur.

Optional Feature:
Macro IDCODE_EN.
- Defined: 32-bit IDCODE register present; opcode 2 selects it; reset/TLR instruction = IDCODE.
- Undefined: no IDCODE register; opcode 2 decodes as BYPASS; reset/TLR instruction = BYPASS (all-1).

Decomposition:
- Package jtag_pkg holds:
  - TAP state enum, 4-bit encoding;
  - opcode constants as functions of IR_WIDTH (EXTEST, SAMPLE, IDCODE, INTEST, USER_BASE, BYPASS);
  - the IR capture pattern.
- One natural sub-module: jtag_tap_fsm, containing the state register, next-state logic and state decode outputs.
- IR, bypass, IDCODE and the TDO mux stay in the top module.

Test Plan:
- reset pulse, then TMS=0 for one clock -> state=RTI; ir_o=2 (IDCODE_EN) or 4'hF; tap_reset falls.
- From RTI, shift IR=4'h1 (SAMPLE) -> TDO during SH_IR emits 1,0,0,0; after UPD_IR ir_o=1, bsr_sel=1, bsr_mode=0.
- IDCODE_EN, ir=2, CAP_DR then 32 SH_DR clocks with TDI=0 -> TDO serialises 32'h1000_0001 LSB first; capture_dr never asserted.
- ir=USER_1 (5), bsr_tdo=0, user_tdo=2'b10 -> user_sel=2'b10, TDO=1 in SH_DR; shift_dr high only in SH_DR cycles, 0 during PA_DR.
- Load opcode 4'hB (undefined), shift pattern 1,0,1 -> TDO reproduces it one clock later (bypass); all strobes 0.
- Mid-SH_IR, hold TMS=1 for 5 clocks -> TLR reached; ir_o=reset value; partial IR discarded. Repeat with reset asserted mid-SH_DR -> next cycle TLR.
